sap_core: RTL and testbench

SAP_CORE -- requirements
Module: sap_core

---
 rtl/sap_core_if.sv | 35 +++
 rtl/sap_core.sv | 169 ++++++++++++++++
 tb/tb_sap_core.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_core_if.sv
// sap_core_if: program-load and status bundle for sap_core.
// SAP_CORE_INSTR_COUNT_EN adds the instr_count signal.
interface sap_core_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          pr_mode;
    logic          pr_we;
    logic [AW-1:0] pr_address;
    logic [DW-1:0] pr_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          halted;
    logic [1:0]    flags;
    logic [2:0]    step;
`ifdef SAP_CORE_INSTR_COUNT_EN
    logic [15:0]   instr_count;
`endif

    modport master (
`ifdef SAP_CORE_INSTR_COUNT_EN
        input  instr_count,
`endif
        output pr_mode, pr_we, pr_address, pr_data,
        input  out_data, out_valid, halted, flags, step
    );

    modport slave (
`ifdef SAP_CORE_INSTR_COUNT_EN
        output instr_count,
`endif
        input  pr_mode, pr_we, pr_address, pr_data,
        output out_data, out_valid, halted, flags, step
    );
endinterface

// File: rtl/sap_core.sv
// sap_core: SAP-1 style accumulator CPU with on-chip program RAM.
// SAP_CORE_INSTR_COUNT_EN adds a saturating retired-instruction counter.
module sap_core #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic      clk,
    input  logic      rst,
    sap_core_if.slave bus
);
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    logic [AW-1:0] pc;
    logic [AW-1:0] mar;
    logic [DW-1:0] ir;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] out_r;
    logic          out_v;
    logic          halted;
    logic          carry;
    logic          zero;
    logic [2:0]    step;

    logic [3:0]    op;
    logic [AW-1:0] opr;
    logic is_lda, is_add, is_sub, is_sta, is_ldi;
    logic is_jmp, is_out, is_hlt, is_alu, is_mem;
    logic jc_take, jz_take, done;

    logic [DW:0]   sum;
    logic [DW:0]   dif;
    logic [DW-1:0] res;
    logic          cout;

    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_wd;

    assign op  = ir[DW-1:DW-4];
    assign opr = ir[AW-1:0];

    assign is_lda  = op == OP_LDA;
    assign is_add  = op == OP_ADD;
    assign is_sub  = op == OP_SUB;
    assign is_sta  = op == OP_STA;
    assign is_ldi  = op == OP_LDI;
    assign is_jmp  = op == OP_JMP;
    assign is_out  = op == OP_OUT;
    assign is_hlt  = op == OP_HLT;
    assign is_alu  = is_add | is_sub;
    assign is_mem  = is_lda | is_sta | is_alu;
    assign jc_take = (op == OP_JC) && carry;
    assign jz_take = (op == OP_JZ) && zero;

    // Last T-state of the current instruction
    assign done = (step == 3'd2 && !is_mem)
               || (step == 3'd3 && (is_lda || is_sta))
               || (step >= 3'd4);

    assign sum  = {1'b0, a} + {1'b0, b};
    assign dif  = {1'b0, a} - {1'b0, b};
    assign res  = is_sub ? dif[DW-1:0] : sum[DW-1:0];
    assign cout = is_sub ? ~dif[DW] : sum[DW];

    // Reset forces step to T0, so an interrupted STA never writes
    assign ram_we = bus.pr_mode ? bus.pr_we
                                : (!halted && step == 3'd3 && is_sta);
    assign ram_wa = bus.pr_mode ? bus.pr_address : mar;
    assign ram_wd = bus.pr_mode ? bus.pr_data : a;

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_wa] <= ram_wd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= '0;
            mar    <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            out_r  <= '0;
            out_v  <= 1'b0;
            halted <= 1'b0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            step   <= '0;
        end else if (bus.pr_mode) begin
            pc     <= '0;
            step   <= '0;
            halted <= 1'b0;
            out_v  <= 1'b0;
        end else if (halted) begin
            out_v  <= 1'b0;
        end else begin
            out_v <= 1'b0;
            step  <= done ? 3'd0 : step + 3'd1;
            unique case (step)
                3'd0: mar <= pc;
                3'd1: begin
                    ir <= ram[mar];
                    pc <= pc + AW'(1);
                end
                3'd2: begin
                    unique case (1'b1)
                        is_mem:  mar <= opr;
                        is_ldi:  a <= DW'(opr);
                        is_jmp:  pc <= opr;
                        jc_take: pc <= opr;
                        jz_take: pc <= opr;
                        is_out: begin
                            out_r <= a;
                            out_v <= 1'b1;
                        end
                        is_hlt:  halted <= 1'b1;
                        default: ;
                    endcase
                end
                3'd3: begin
                    unique case (1'b1)
                        is_lda:  a <= ram[mar];
                        is_alu:  b <= ram[mar];
                        default: ;
                    endcase
                end
                3'd4: begin
                    a     <= res;
                    carry <= cout;
                    zero  <= (res == '0);
                end
                default: ;
            endcase
        end
    end

`ifdef SAP_CORE_INSTR_COUNT_EN
    logic [15:0] icnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            icnt <= '0;
        else if (bus.pr_mode)
            icnt <= '0;
        else if (!halted && done && icnt != 16'hFFFF)
            icnt <= icnt + 16'd1;
    end

    assign bus.instr_count = icnt;
`endif

    assign bus.out_data  = out_r;
    assign bus.out_valid = out_v;
    assign bus.halted    = halted;
    assign bus.flags     = {carry, zero};
    assign bus.step      = step;
endmodule

// File: tb/tb_sap_core.sv
// tb_sap_core: directed programs for sap_core, OUT values checked
// through an expected-output queue.
module tb_sap_core;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   pulses;
    logic [7:0] sb[$];

    sap_core_if #(.DW(8), .AW(4)) bus ();

    sap_core #(.DW(8), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic prog_begin();
        bus.pr_we   = 1'b0;
        bus.pr_mode = 1'b1;
        tick(1);
    endtask

    task automatic wr(input logic [3:0] ad, input logic [7:0] d);
        bus.pr_address = ad;
        bus.pr_data    = d;
        bus.pr_we      = 1'b1;
        tick(1);
        bus.pr_we      = 1'b0;
    endtask

    task automatic prog_end();
        bus.pr_we   = 1'b0;
        bus.pr_mode = 1'b0;
        pulses      = 0;
    endtask

    task automatic run_halt(input string tag, input int limit);
        int n;
        n = 0;
        while (bus.halted !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(bus.halted), 32'd1);
        tick(2);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulses = 0;
        rst = 1'b0;
        bus.pr_mode = 1'b0;
        bus.pr_we = 1'b0;
        bus.pr_address = '0;
        bus.pr_data = '0;
        tick(2);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_flags", 32'(bus.flags), 32'd0);
        chk("rst_step", 32'(bus.step), 32'd0);
        rst = 1'b1;

        // 28 + 14 -> 42, halt visible 15 cycles after load ends
        prog_begin();
        wr(4'd0, 8'h1E);
        wr(4'd1, 8'h2F);
        wr(4'd2, 8'hE0);
        wr(4'd3, 8'hF0);
        wr(4'd14, 8'd28);
        wr(4'd15, 8'd14);
        chk("pm_step", 32'(bus.step), 32'd0);
        sb.push_back(8'd42);
        prog_end();
        chk("t1_first_step", 32'(bus.step), 32'd0);
        tick(14);
        chk("t1_not_halted_c14", 32'(bus.halted), 32'd0);
        tick(1);
        chk("t1_halted_c15", 32'(bus.halted), 32'd1);
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_out", 32'(bus.out_data), 32'd42);
        chk("t1_flags", 32'(bus.flags), 32'b00);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
`ifdef SAP_CORE_INSTR_COUNT_EN
        chk("t1_icnt", 32'(bus.instr_count), 32'd4);
`endif
        tick(6);
        chk("t1_still_halted", 32'(bus.halted), 32'd1);
        chk("t1_out_held", 32'(bus.out_data), 32'd42);
`ifdef SAP_CORE_INSTR_COUNT_EN
        chk("t1_icnt_held", 32'(bus.instr_count), 32'd4);
`endif

        // LDI 15; SUB 15 -> 0, flags 11; JZ 9 taken outputs 0
        prog_begin();
        chk("pm_clears_halt", 32'(bus.halted), 32'd0);
        chk("pm_keeps_out", 32'(bus.out_data), 32'd42);
        wr(4'd0, 8'h5F);
        wr(4'd1, 8'h3D);
        wr(4'd2, 8'h89);
        wr(4'd3, 8'h57);
        wr(4'd4, 8'hE0);
        wr(4'd5, 8'hF0);
        wr(4'd9, 8'hE0);
        wr(4'd10, 8'hF0);
        wr(4'd13, 8'd15);
        sb.push_back(8'd0);
        prog_end();
        run_halt("t2_halt", 200);
        chk("t2_flags", 32'(bus.flags), 32'b11);
        chk("t2_pulses", 32'(pulses), 32'd1);

        // 200 + 100 -> 44 carry; JC 6 taken skips LDI 1/OUT
        prog_begin();
        wr(4'd0, 8'h1C);
        wr(4'd1, 8'h2D);
        wr(4'd2, 8'hE0);
        wr(4'd3, 8'h76);
        wr(4'd4, 8'h51);
        wr(4'd5, 8'hE0);
        wr(4'd6, 8'hF0);
        wr(4'd12, 8'd200);
        wr(4'd13, 8'd100);
        sb.push_back(8'd44);
        prog_end();
        run_halt("t3_halt", 200);
        chk("t3_flags", 32'(bus.flags), 32'b10);
        chk("t3_pulses", 32'(pulses), 32'd1);

        // 3 - 100 borrows: carry 0, JC 5 not taken
        prog_begin();
        wr(4'd0, 8'h53);
        wr(4'd1, 8'h3D);
        wr(4'd2, 8'h75);
        wr(4'd3, 8'hE0);
        wr(4'd4, 8'hF0);
        wr(4'd5, 8'hF0);
        sb.push_back(8'd159);
        prog_end();
        run_halt("t4_halt", 200);
        chk("t4_flags", 32'(bus.flags), 32'b00);
        chk("t4_pulses", 32'(pulses), 32'd1);

        // STA then LDA from the same word
        prog_begin();
        wr(4'd0, 8'h59);
        wr(4'd1, 8'h4C);
        wr(4'd2, 8'h1C);
        wr(4'd3, 8'hE0);
        wr(4'd4, 8'hF0);
        sb.push_back(8'd9);
        prog_end();
        run_halt("t5_halt", 200);
        chk("t5_flags_unchanged", 32'(bus.flags), 32'b00);

        // NOP-only image: 16 instructions, no output
        prog_begin();
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h00);
        prog_end();
        tick(48);
        chk("t6_step", 32'(bus.step), 32'd0);
        chk("t6_pulses", 32'(pulses), 32'd0);
        chk("t6_halted", 32'(bus.halted), 32'd0);
`ifdef SAP_CORE_INSTR_COUNT_EN
        chk("t6_icnt", 32'(bus.instr_count), 32'd16);
`endif
        // OUT at 0 then 15 NOPs: PC wrap re-runs OUT
        prog_begin();
        wr(4'd0, 8'hE0);
        sb.push_back(8'd9);
        sb.push_back(8'd9);
        prog_end();
        tick(53);
        chk("t6_wrap_pulses", 32'(pulses), 32'd2);
        chk("t6_wrap_sb", 32'(sb.size()), 32'd0);

        // Reset during STA T3, then pr_mode during STA T3
        prog_begin();
        wr(4'd0, 8'h55);
        wr(4'd1, 8'h4C);
        wr(4'd2, 8'hE0);
        wr(4'd3, 8'hF0);
        wr(4'd12, 8'h77);
        prog_end();
        tick(6);
        chk("t7_sta_t3", 32'(bus.step), 32'd3);
        rst = 1'b0;
        tick(1);
        chk("t7_rst_step", 32'(bus.step), 32'd0);
        chk("t7_rst_out", 32'(bus.out_data), 32'd0);
        chk("t7_rst_flags", 32'(bus.flags), 32'd0);
        chk("t7_rst_halted", 32'(bus.halted), 32'd0);
        rst = 1'b1;
        tick(6);
        chk("t7_restart_t3", 32'(bus.step), 32'd3);
        prog_begin();
        chk("t7_abort_step", 32'(bus.step), 32'd0);
        chk("t7_abort_out", 32'(bus.out_data), 32'd0);
        wr(4'd0, 8'h1C);
        wr(4'd1, 8'hE0);
        wr(4'd2, 8'hF0);
        sb.push_back(8'h77);
        prog_end();
        run_halt("t7_halt", 200);
        chk("t7_pulses", 32'(pulses), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
